// File: rtl/t_state_sequencer.sv
// T-state and machine-cycle sequencer: advances XPT/CMA from the decoders' hold/end
// requests, samples the WAIT pin during T2 and counts inserted wait states.
module t_state_sequencer #(
    parameter int M_WIDTH    = 3,
    parameter int M_LAST     = 5,
    parameter int WCNT_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  notRESET,
    input  logic                  notWAIT,
    input  logic                  PR_Halt_XPT,
    input  logic                  P2_End_M,
    input  logic                  P2_End_Instr,
    output logic [1:0]            XPT,
    output logic [1:0]            notXPT,
    output logic                  TWAIT,
    output logic [M_WIDTH-1:0]    CMA,
    output logic                  M1,
    output logic [WCNT_WIDTH-1:0] WCNT,
    output logic                  OVF
);

    localparam logic [1:0] ST_T1 = 2'd0;
    localparam logic [1:0] ST_T2 = 2'd1;
    localparam logic [1:0] ST_T4 = 2'd3;
    localparam logic [M_WIDTH-1:0] LP_M_LAST = M_LAST[M_WIDTH-1:0];

    logic [1:0]            r_xpt;
    logic [1:0]            r_not_xpt;
    logic                  r_twait;
    logic [M_WIDTH-1:0]    r_cma;
    logic [WCNT_WIDTH-1:0] r_wcnt;
    logic                  r_ovf;

    logic [1:0]            w_xpt_nxt;
    logic [M_WIDTH-1:0]    w_cma_nxt;
    logic [WCNT_WIDTH-1:0] w_wcnt_nxt;
    logic                  w_ovf_nxt;
    logic                  w_twait_nxt;

    always_comb begin
        w_xpt_nxt  = r_xpt;
        w_cma_nxt  = r_cma;
        w_wcnt_nxt = r_wcnt;
        w_ovf_nxt  = r_ovf;
        if (P2_End_Instr) begin
            w_xpt_nxt  = ST_T1;
            w_cma_nxt  = '0;
            w_wcnt_nxt = '0;
            w_ovf_nxt  = 1'b0;
        end else if (P2_End_M) begin
            w_xpt_nxt  = ST_T1;
            w_wcnt_nxt = '0;
            if (r_cma < LP_M_LAST) begin
                w_cma_nxt = r_cma + 1'b1;
            end else begin
                w_ovf_nxt = 1'b1;
            end
        end else if (PR_Halt_XPT) begin
            if (r_wcnt != '1) begin
                w_wcnt_nxt = r_wcnt + 1'b1;
            end
        end else if (r_xpt != ST_T4) begin
            w_xpt_nxt = r_xpt + 2'd1;
        end
    end

    // The wait pin only matters for the state being entered, so T2 entry can already flag a wait.
    assign w_twait_nxt = (w_xpt_nxt == ST_T2) & ~notWAIT;

    always_ff @(posedge CLK or negedge notRESET) begin
        if (!notRESET) begin
            r_xpt     <= ST_T1;
            r_not_xpt <= ~ST_T1;
            r_twait   <= 1'b0;
            r_cma     <= '0;
            r_wcnt    <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_xpt     <= w_xpt_nxt;
            r_not_xpt <= ~w_xpt_nxt;
            r_twait   <= w_twait_nxt;
            r_cma     <= w_cma_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_ovf     <= w_ovf_nxt;
        end
    end

    assign XPT    = r_xpt;
    assign notXPT = r_not_xpt;
    assign TWAIT  = r_twait;
    assign CMA    = r_cma;
    assign M1     = (r_cma == '0);
    assign WCNT   = r_wcnt;
    assign OVF    = r_ovf;

endmodule

// File: tb/tb_t_state_sequencer.sv
// Directed bench for t_state_sequencer: each task drives one scenario and
// checks the full output vector against hand-computed values.
module tb_t_state_sequencer;

    logic       CLK = 1'b0;
    logic       notRESET = 1'b0;
    logic       notWAIT = 1'b1;
    logic       halt_drv = 1'b0;
    logic       halt_auto = 1'b0;
    logic       P2_End_M = 1'b0;
    logic       P2_End_Instr = 1'b0;
    logic       PR_Halt_XPT;
    logic [1:0] XPT;
    logic [1:0] notXPT;
    logic       TWAIT;
    logic [2:0] CMA;
    logic       M1;
    logic [3:0] WCNT;
    logic       OVF;

    int n_cmp = 0;
    int n_bad = 0;

    // Downstream decoder behaviour: halt while in T2 with a registered wait.
    assign PR_Halt_XPT = halt_auto ? ((XPT == 2'd1) && TWAIT) : halt_drv;

    t_state_sequencer #(.M_WIDTH(3), .M_LAST(5), .WCNT_WIDTH(4)) dut (
        .CLK(CLK), .notRESET(notRESET), .notWAIT(notWAIT), .PR_Halt_XPT(PR_Halt_XPT),
        .P2_End_M(P2_End_M), .P2_End_Instr(P2_End_Instr), .XPT(XPT), .notXPT(notXPT),
        .TWAIT(TWAIT), .CMA(CMA), .M1(M1), .WCNT(WCNT), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    // Output vector layout: {XPT, notXPT, TWAIT, CMA, M1, WCNT, OVF}
    function automatic logic [13:0] obs();
        return {XPT, notXPT, TWAIT, CMA, M1, WCNT, OVF};
    endfunction

    function automatic logic [13:0] expv(input logic [1:0] x, input logic tw,
                                         input logic [2:0] c, input logic [3:0] w,
                                         input logic o);
        return {x, ~x, tw, c, (c == 3'd0), w, o};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        notRESET = 1'b0; notWAIT = 1'b1; halt_drv = 1'b0; halt_auto = 1'b0;
        P2_End_M = 1'b0; P2_End_Instr = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        notRESET = 1'b1;
    endtask

    task automatic test_reset();
        logic [1:0] xe;
        notRESET = 1'b0;
        step();
        n_cmp++;
        if (obs() !== expv(2'd0, 1'b0, 3'd0, 4'd0, 1'b0)) begin
            n_bad++; $display("FAIL reset_hold: got %b want %b", obs(), expv(2'd0, 1'b0, 3'd0, 4'd0, 1'b0));
        end
        @(negedge CLK);
        notRESET = 1'b1;
        n_cmp++;
        if (obs() !== expv(2'd0, 1'b0, 3'd0, 4'd0, 1'b0)) begin
            n_bad++; $display("FAIL reset_release: got %b want %b", obs(), expv(2'd0, 1'b0, 3'd0, 4'd0, 1'b0));
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            xe = (i >= 3) ? 2'd3 : 2'(i);
            n_cmp++;
            if (obs() !== expv(xe, 1'b0, 3'd0, 4'd0, 1'b0)) begin
                n_bad++; $display("FAIL free_run[%0d]: got %b want %b", i, obs(), expv(xe, 1'b0, 3'd0, 4'd0, 1'b0));
            end
        end
    endtask

    task automatic test_wait();
        logic [13:0] tbl [6];
        do_reset();
        notWAIT = 1'b0;
        halt_auto = 1'b1;
        tbl[0] = expv(2'd1, 1'b1, 3'd0, 4'd0, 1'b0);
        tbl[1] = expv(2'd1, 1'b1, 3'd0, 4'd1, 1'b0);
        tbl[2] = expv(2'd1, 1'b1, 3'd0, 4'd2, 1'b0);
        tbl[3] = expv(2'd1, 1'b0, 3'd0, 4'd3, 1'b0);
        tbl[4] = expv(2'd2, 1'b0, 3'd0, 4'd3, 1'b0);
        tbl[5] = expv(2'd3, 1'b0, 3'd0, 4'd3, 1'b0);
        for (int i = 0; i < 6; i++) begin
            notWAIT = (i == 3 || i == 4) ? 1'b1 : 1'b0;
            step();
            n_cmp++;
            if (obs() !== tbl[i]) begin
                n_bad++; $display("FAIL wait_loop[%0d]: got %b want %b", i, obs(), tbl[i]);
            end
        end
        notWAIT = 1'b1;
        halt_auto = 1'b0;
    endtask

    task automatic test_end_m();
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            step(); step();
            P2_End_M = 1'b1;
            step();
            P2_End_M = 1'b0;
            n_cmp++;
            if (obs() !== expv(2'd0, 1'b0, (i > 5) ? 3'd5 : 3'(i), 4'd0, i > 5)) begin
                n_bad++; $display("FAIL end_m[%0d]: got %b want %b", i, obs(),
                                  expv(2'd0, 1'b0, (i > 5) ? 3'd5 : 3'(i), 4'd0, i > 5));
            end
        end
        step(); step();
        n_cmp++;
        if (obs() !== expv(2'd2, 1'b0, 3'd5, 4'd0, 1'b1)) begin
            n_bad++; $display("FAIL ovf_sticky: got %b want %b", obs(), expv(2'd2, 1'b0, 3'd5, 4'd0, 1'b1));
        end
        P2_End_Instr = 1'b1;
        step();
        P2_End_Instr = 1'b0;
        n_cmp++;
        if (obs() !== expv(2'd0, 1'b0, 3'd0, 4'd0, 1'b0)) begin
            n_bad++; $display("FAIL end_instr_clear: got %b want %b", obs(), expv(2'd0, 1'b0, 3'd0, 4'd0, 1'b0));
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        P2_End_M = 1'b1;
        step(); step();
        n_cmp++;
        if (obs() !== expv(2'd0, 1'b0, 3'd2, 4'd0, 1'b0)) begin
            n_bad++; $display("FAIL back_to_back_end_m: got %b want %b", obs(), expv(2'd0, 1'b0, 3'd2, 4'd0, 1'b0));
        end
        P2_End_Instr = 1'b1;
        step();
        P2_End_Instr = 1'b0;
        P2_End_M = 1'b0;
        n_cmp++;
        if (obs() !== expv(2'd0, 1'b0, 3'd0, 4'd0, 1'b0)) begin
            n_bad++; $display("FAIL instr_beats_end_m: got %b want %b", obs(), expv(2'd0, 1'b0, 3'd0, 4'd0, 1'b0));
        end
        step(); step();
        halt_drv = 1'b1;
        step();
        n_cmp++;
        if (obs() !== expv(2'd2, 1'b0, 3'd0, 4'd1, 1'b0)) begin
            n_bad++; $display("FAIL halt_at_t3: got %b want %b", obs(), expv(2'd2, 1'b0, 3'd0, 4'd1, 1'b0));
        end
        P2_End_M = 1'b1;
        step();
        P2_End_M = 1'b0;
        halt_drv = 1'b0;
        n_cmp++;
        if (obs() !== expv(2'd0, 1'b0, 3'd1, 4'd0, 1'b0)) begin
            n_bad++; $display("FAIL end_m_beats_halt: got %b want %b", obs(), expv(2'd0, 1'b0, 3'd1, 4'd0, 1'b0));
        end
    endtask

    task automatic test_halt_saturate();
        logic [3:0] we;
        do_reset();
        step(); step(); step();
        halt_drv = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            we = (i > 15) ? 4'd15 : 4'(i);
            n_cmp++;
            if (obs() !== expv(2'd3, 1'b0, 3'd0, we, 1'b0)) begin
                n_bad++; $display("FAIL wcnt_sat[%0d]: got %b want %b", i, obs(), expv(2'd3, 1'b0, 3'd0, we, 1'b0));
            end
        end
        halt_drv = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        P2_End_M = 1'b1;
        step(); step(); step();
        P2_End_M = 1'b0;
        halt_drv = 1'b1;
        step(); step(); step(); step();
        halt_drv = 1'b0;
        step(); step();
        n_cmp++;
        if (obs() !== expv(2'd2, 1'b0, 3'd3, 4'd4, 1'b0)) begin
            n_bad++; $display("FAIL mid_setup: got %b want %b", obs(), expv(2'd2, 1'b0, 3'd3, 4'd4, 1'b0));
        end
        #2;
        notRESET = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== expv(2'd0, 1'b0, 3'd0, 4'd0, 1'b0)) begin
            n_bad++; $display("FAIL async_reset: got %b want %b", obs(), expv(2'd0, 1'b0, 3'd0, 4'd0, 1'b0));
        end
        @(negedge CLK);
        notRESET = 1'b1;
        step();
        n_cmp++;
        if (obs() !== expv(2'd1, 1'b0, 3'd0, 4'd0, 1'b0)) begin
            n_bad++; $display("FAIL first_edge_after_reset: got %b want %b", obs(), expv(2'd1, 1'b0, 3'd0, 4'd0, 1'b0));
        end
    endtask

    initial begin
        test_reset();
        test_wait();
        test_end_m();
        test_simultaneous();
        test_halt_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
